// File: rtl/hazard_sequencer.sv
// Hazard controller for a 5-stage MIPS pipeline: load-use bubbles, control-transfer
// fetch squashing, and a saturating count of PC-hold cycles.
//
// state     | meaning
// IDLE      | normal flow; Mealy decode of load-use / control hazards in ID
// CTRL_WAIT | remaining fetch-squash cycles after a control instruction
module hazard_sequencer #(
  parameter int CTRL_BUBBLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [5:0]       id_op,
  input  logic [5:0]       id_funct,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_memtoreg,
  input  logic [4:0]       ex_rt,
  output logic             pc_enable,
  output logic             if_id_enable,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [2:0] CNT_LOAD = 3'(CTRL_BUBBLES - 1);

  typedef enum logic {IDLE, CTRL_WAIT} state_t;

  state_t     state;
  logic [2:0] cnt;
  logic       is_ctrl;
  logic       uses_rt;
  logic       load_use;

  always_comb begin
    is_ctrl = id_valid &&
              ((id_op == OP_J) || (id_op == OP_JAL) || (id_op == OP_BEQ) ||
               (id_op == OP_BNE) || ((id_op == OP_RTYPE) && (id_funct == FN_JR)));
    uses_rt = (id_op == OP_RTYPE) || (id_op == OP_BEQ) ||
              (id_op == OP_BNE) || (id_op == OP_SW);
    load_use = id_valid && ex_memtoreg && (ex_rt != 5'd0) &&
               ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));
  end

  // Outputs follow the inputs in IDLE and the state in CTRL_WAIT; reset forces safe values.
  always_comb begin
    pc_enable    = 1'b0;
    if_id_enable = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b1;
    busy         = 1'b0;
    if (!reset) begin
      case (state)
        CTRL_WAIT: begin
          if_id_enable = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b0;
          busy         = 1'b1;
        end
        default: begin
          if (load_use) begin
            id_ex_bubble = 1'b1;
          end else if (is_ctrl) begin
            if_id_enable = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b0;
          end else begin
            pc_enable    = 1'b1;
            if_id_enable = 1'b1;
            id_ex_bubble = 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= 3'd0;
      stall_cycles <= '0;
    end else begin
      if (!pc_enable && (stall_cycles != {CNT_W{1'b1}}))
        stall_cycles <= stall_cycles + 1'b1;
      case (state)
        CTRL_WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1)
            state <= IDLE;
        end
        default: begin
          // A single-cycle squash is fully covered by the detect cycle.
          if (!load_use && is_ctrl && (CTRL_BUBBLES > 1)) begin
            cnt   <= CNT_LOAD;
            state <= CTRL_WAIT;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Bench for hazard_sequencer: three instances (2, 4 and 1 squash cycles) share the
// stimulus and are compared against a remaining-squash-cycles reference model.
module tb_hazard_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [5:0] id_op, id_funct;
  logic [4:0] id_rs, id_rt;
  logic       ex_memtoreg;
  logic [4:0] ex_rt;

  // {pc_enable, if_id_enable, if_id_flush, id_ex_bubble, busy}
  logic [4:0]  o_a, o_b, o_c;
  logic [15:0] st_a, st_b;
  logic [3:0]  st_c;

  int n_cmp = 0;
  int n_bad = 0;

  int          cb[3]   = '{2, 4, 1};
  int          smax[3] = '{65535, 65535, 15};
  int          rem[3];
  int          stall[3];
  logic [4:0]  eo[3];

  always #5 clk = ~clk;

  hazard_sequencer #(.CTRL_BUBBLES(2), .CNT_W(16)) u_a (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_op(id_op), .id_funct(id_funct),
    .id_rs(id_rs), .id_rt(id_rt), .ex_memtoreg(ex_memtoreg), .ex_rt(ex_rt),
    .pc_enable(o_a[4]), .if_id_enable(o_a[3]), .if_id_flush(o_a[2]),
    .id_ex_bubble(o_a[1]), .busy(o_a[0]), .stall_cycles(st_a));

  hazard_sequencer #(.CTRL_BUBBLES(4), .CNT_W(16)) u_b (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_op(id_op), .id_funct(id_funct),
    .id_rs(id_rs), .id_rt(id_rt), .ex_memtoreg(ex_memtoreg), .ex_rt(ex_rt),
    .pc_enable(o_b[4]), .if_id_enable(o_b[3]), .if_id_flush(o_b[2]),
    .id_ex_bubble(o_b[1]), .busy(o_b[0]), .stall_cycles(st_b));

  hazard_sequencer #(.CTRL_BUBBLES(1), .CNT_W(4)) u_c (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_op(id_op), .id_funct(id_funct),
    .id_rs(id_rs), .id_rt(id_rt), .ex_memtoreg(ex_memtoreg), .ex_rt(ex_rt),
    .pc_enable(o_c[4]), .if_id_enable(o_c[3]), .if_id_flush(o_c[2]),
    .id_ex_bubble(o_c[1]), .busy(o_c[0]), .stall_cycles(st_c));

  function automatic logic [4:0] get_o(input int k);
    case (k)
      0:       return o_a;
      1:       return o_b;
      default: return o_c;
    endcase
  endfunction

  function automatic logic [15:0] get_st(input int k);
    case (k)
      0:       return st_a;
      1:       return st_b;
      default: return {12'd0, st_c};
    endcase
  endfunction

  function automatic bit ref_ctrl();
    return id_valid && ((id_op inside {6'd2, 6'd3, 6'd4, 6'd5}) ||
                        (id_op == 6'd0 && id_funct == 6'd8));
  endfunction

  function automatic bit ref_lu();
    bit rt_src;
    rt_src = id_op inside {6'd0, 6'd4, 6'd5, 6'd43};
    return id_valid && ex_memtoreg && ex_rt != 0 &&
           (ex_rt == id_rs || (rt_src && ex_rt == id_rt));
  endfunction

  task automatic eval_model();
    for (int k = 0; k < 3; k++) begin
      if (reset)           eo[k] = 5'b00010;
      else if (rem[k] > 0) eo[k] = 5'b01101;
      else if (ref_lu())   eo[k] = 5'b00010;
      else if (ref_ctrl()) eo[k] = 5'b01100;
      else                 eo[k] = 5'b11000;
    end
  endtask

  task automatic advance_model();
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        rem[k] = 0;
        stall[k] = 0;
      end else begin
        if (!eo[k][4] && stall[k] < smax[k]) stall[k]++;
        if (rem[k] > 0) rem[k]--;
        else if (!ref_lu() && ref_ctrl()) rem[k] = cb[k] - 1;
      end
    end
  endtask

  task automatic set_in(input logic v, input logic [5:0] op, input logic [5:0] fn,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic mem, input logic [4:0] xrt);
    id_valid = v; id_op = op; id_funct = fn; id_rs = rs; id_rt = rt;
    ex_memtoreg = mem; ex_rt = xrt;
  endtask

  task automatic set_nop();
    set_in(1'b1, 6'd0, 6'h20, 5'd1, 5'd2, 1'b0, 5'd0);
  endtask

  task automatic settle();
    @(negedge clk);
    eval_model();
  endtask

  task automatic tick();
    @(posedge clk);
    advance_model();
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_nop();
    @(posedge clk);
    #2;
    for (int k = 0; k < 3; k++) begin
      rem[k] = 0;
      stall[k] = 0;
    end
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_nop();
    @(posedge clk);
    #2;
    for (int k = 0; k < 3; k++) begin
      rem[k] = 0;
      stall[k] = 0;
    end
    eval_model();
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (get_o(k) !== 5'b00010 || get_st(k) !== 16'd0) begin
        n_bad++;
        $display("FAIL reset inst%0d: outputs %b stall %0d, expected 00010 stall 0",
                 k, get_o(k), get_st(k));
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_nops();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      set_nop();
      settle();
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (get_o(k) !== eo[k] || get_st(k) !== 16'(stall[k])) begin
          n_bad++;
          $display("FAIL nops inst%0d cyc%0d: out %b st %0d, expected %b st %0d",
                   k, c, get_o(k), get_st(k), eo[k], stall[k]);
        end
      end
      tick();
    end
    n_cmp++;
    if (st_a !== 16'd0) begin
      n_bad++;
      $display("FAIL nops_stall: stall_cycles %0d, expected 0", st_a);
    end
  endtask

  task automatic test_beq();
    logic [4:0] pat[4] = '{5'b01100, 5'b01101, 5'b11000, 5'b11000};
    do_reset();
    for (int c = 0; c < 4; c++) begin
      if (c == 0) set_in(1'b1, 6'd4, 6'd0, 5'd3, 5'd4, 1'b0, 5'd0);
      else        set_nop();
      settle();
      n_cmp++;
      if (o_a !== pat[c]) begin
        n_bad++;
        $display("FAIL beq_seq cyc%0d: out %b, expected %b", c, o_a, pat[c]);
      end
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (get_o(k) !== eo[k] || get_st(k) !== 16'(stall[k])) begin
          n_bad++;
          $display("FAIL beq inst%0d cyc%0d: out %b st %0d, expected %b st %0d",
                   k, c, get_o(k), get_st(k), eo[k], stall[k]);
        end
      end
      tick();
    end
    n_cmp++;
    if (st_a !== 16'd2) begin
      n_bad++;
      $display("FAIL beq_stall: stall_cycles %0d, expected 2", st_a);
    end
  endtask

  task automatic test_load_use();
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      for (int c = 0; c < 3; c++) begin
        if (c == 0) set_in(1'b1, 6'd0, 6'h20, 5'd8, 5'd2, 1'b1, (pass == 0) ? 5'd8 : 5'd0);
        else        set_nop();
        settle();
        for (int k = 0; k < 3; k++) begin
          n_cmp++;
          if (get_o(k) !== eo[k] || get_st(k) !== 16'(stall[k])) begin
            n_bad++;
            $display("FAIL load_use p%0d inst%0d cyc%0d: out %b st %0d, expected %b st %0d",
                     pass, k, c, get_o(k), get_st(k), eo[k], stall[k]);
          end
        end
        tick();
      end
      n_cmp++;
      if (st_a !== ((pass == 0) ? 16'd1 : 16'd0)) begin
        n_bad++;
        $display("FAIL load_use_stall p%0d: stall_cycles %0d", pass, st_a);
      end
    end
  endtask

  task automatic test_bne_load();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      if (c == 0)      set_in(1'b1, 6'd5, 6'd0, 5'd1, 5'd9, 1'b1, 5'd9);
      else if (c == 1) set_in(1'b1, 6'd5, 6'd0, 5'd1, 5'd9, 1'b0, 5'd0);
      else             set_nop();
      settle();
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (get_o(k) !== eo[k] || get_st(k) !== 16'(stall[k])) begin
          n_bad++;
          $display("FAIL bne_load inst%0d cyc%0d: out %b st %0d, expected %b st %0d",
                   k, c, get_o(k), get_st(k), eo[k], stall[k]);
        end
      end
      tick();
    end
    n_cmp++;
    if (st_a !== 16'd3) begin
      n_bad++;
      $display("FAIL bne_load_stall: stall_cycles %0d, expected 3", st_a);
    end
  endtask

  task automatic test_jr_reset();
    do_reset();
    set_in(1'b1, 6'd0, 6'd8, 5'd31, 5'd0, 1'b0, 5'd0);
    settle();
    n_cmp++;
    if (o_b !== 5'b01100) begin
      n_bad++;
      $display("FAIL jr_detect: out %b, expected 01100", o_b);
    end
    tick();
    set_nop();
    settle();
    n_cmp++;
    if (o_b !== 5'b01101 || st_b !== 16'd1) begin
      n_bad++;
      $display("FAIL jr_wait: out %b st %0d, expected 01101 st 1", o_b, st_b);
    end
    reset = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      rem[k] = 0;
      stall[k] = 0;
    end
    eval_model();
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (get_o(k) !== 5'b00010 || get_st(k) !== 16'd0) begin
        n_bad++;
        $display("FAIL async_reset inst%0d: out %b st %0d, expected 00010 st 0",
                 k, get_o(k), get_st(k));
      end
    end
    tick();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      settle();
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (get_o(k) !== eo[k] || get_st(k) !== 16'(stall[k])) begin
          n_bad++;
          $display("FAIL post_reset inst%0d cyc%0d: out %b st %0d, expected %b st %0d",
                   k, c, get_o(k), get_st(k), eo[k], stall[k]);
        end
      end
      tick();
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int c = 0; c < 20; c++) begin
      set_in(1'b1, 6'd2, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0);
      settle();
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (get_o(k) !== eo[k] || get_st(k) !== 16'(stall[k])) begin
          n_bad++;
          $display("FAIL sat inst%0d cyc%0d: out %b st %0d, expected %b st %0d",
                   k, c, get_o(k), get_st(k), eo[k], stall[k]);
        end
      end
      tick();
    end
    n_cmp++;
    if (st_c !== 4'd15) begin
      n_bad++;
      $display("FAIL sat_value: stall_cycles %0d, expected 15", st_c);
    end
  endtask

  task automatic test_random();
    logic [5:0] ops[8] = '{6'd0, 6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd43, 6'd35};
    do_reset();
    for (int c = 0; c < 400; c++) begin
      set_in(1'($urandom_range(0, 7) != 0), ops[$urandom_range(0, 7)],
             ($urandom_range(0, 2) == 0) ? 6'd8 : 6'h20,
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)));
      settle();
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (get_o(k) !== eo[k] || get_st(k) !== 16'(stall[k])) begin
          n_bad++;
          $display("FAIL random inst%0d cyc%0d: out %b st %0d, expected %b st %0d",
                   k, c, get_o(k), get_st(k), eo[k], stall[k]);
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_nops();
    test_beq();
    test_load_use();
    test_bne_load();
    test_jr_reset();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
- Sequential hazard controller for the 5-stage MIPS pipeline.
- Watches the instruction in ID and the load in EX, and drives the PC, IF/ID and ID/EX pipeline-register controls.
- Two hazard types:
  - Control hazards (J, JAL, JR, BEQ, BNE) squash fetch for a programmable number of cycles.
  - Load-use hazards insert a single ID/EX bubble.
- Keeps a saturating stall-cycle counter for performance measurement.

Parameters:
CTRL_BUBBLES, 2, total fetch-squash cycles per control instruction, including the detect cycle; legal range 1..7
CNT_W, 16, width of stall_cycles performance counter

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-high reset
id_valid  input  1  ID stage holds a real instruction
id_op  input  6  opcode in ID
id_funct  input  6  funct field in ID; meaningful only when id_op=000000
id_rs  input  5  rs field in ID
id_rt  input  5  rt field in ID
ex_memtoreg  input  1  instruction in EX is LW
ex_rt  input  5  destination register of the LW in EX
pc_enable  output  1  1 = PC advances; 0 = PC holds its sequential value
if_id_enable  output  1  1 = IF/ID register loads
if_id_flush  output  1  1 = IF/ID loads a NOP instead of the fetched word
id_ex_bubble  output  1  1 = ID/EX loads all-zero control (NOP)
busy  output  1  state is CTRL_WAIT
stall_cycles  output  CNT_W  count of cycles with pc_enable=0

Behaviour:
- Interface: one clock, clk. reset is asynchronous and active-high.
  - While reset=1: state=IDLE, cnt=0, stall_cycles=0, pc_enable=0, if_id_enable=0, if_id_flush=0, id_ex_bubble=1, busy=0.
- Decode:
  - is_ctrl = id_valid and (op in {000010 J, 000011 JAL, 000100 BEQ, 000101 BNE} or (op=000000 and funct=001000 JR)).
  - uses_rt = op in {000000 R-type, 000100, 000101, 101011 SW}.
  - load_use = id_valid and ex_memtoreg and ex_rt!=0 and (ex_rt==id_rs or (uses_rt and ex_rt==id_rt)).
- Outputs are Mealy in IDLE and Moore in CTRL_WAIT.
- IDLE, evaluated in priority order:
  1. load_use: pc_enable=0, if_id_enable=0, if_id_flush=0, id_ex_bubble=1; stay in IDLE. The instruction is held one cycle. This takes priority over is_ctrl: a branch that depends on a load stalls first and is re-evaluated next cycle.
  2. is_ctrl (no load_use): pc_enable=0, if_id_enable=1, if_id_flush=1, id_ex_bubble=0, so the control instruction itself proceeds to EX.
     - If CTRL_BUBBLES=1: stay in IDLE.
     - Else: cnt<=CTRL_BUBBLES-1 and go to CTRL_WAIT.
  3. Otherwise: pc_enable=1, if_id_enable=1, if_id_flush=0, id_ex_bubble=0.
- CTRL_WAIT:
  - Outputs: pc_enable=0, if_id_enable=1, if_id_flush=1, id_ex_bubble=0, busy=1.
  - id_* and ex_* inputs are ignored; ID holds a flushed NOP.
  - cnt<=cnt-1 each cycle; when cnt==1, next state is IDLE.
- Total pc_enable=0 cycles per control instruction = CTRL_BUBBLES exactly.
  - A control instruction appearing in the first IDLE cycle after CTRL_WAIT starts a fresh sequence with no gap requirement.
- Branch/jump target loads into PC are driven by the datapath and override pc_enable. This block gates only sequential PC+4.
- stall_cycles:
  - Increments on every clock edge where pc_enable=0 and reset=0.
  - Saturates at all-ones and never wraps.
- cnt width is 3 bits.
- Reset asserted mid-CTRL_WAIT aborts the sequence immediately (asynchronous). After release, the first cycle is IDLE evaluation.

Test Plan:
- Reset then NOPs (id_valid=1, op=000000, funct=100000, no load in EX) -> pc_enable=1, if_id_enable=1, bubble=0 every cycle; stall_cycles=0.
- BEQ (op=000100) in ID for 1 cycle, CTRL_BUBBLES=2 -> pc_enable=0 for exactly 2 cycles; if_id_flush=1 both cycles; busy=1 only in cycle 2; stall_cycles=2; pc_enable=1 in cycle 3.
- LW in EX with ex_rt=8; ID is ADD with id_rs=8 -> 1 cycle of pc_enable=0, if_id_enable=0, id_ex_bubble=1; next cycle (ex_memtoreg=0) normal flow. Same stimulus with ex_rt=0 -> no stall.
- BNE with id_rt=9 and LW in EX with ex_rt=9 -> bubble cycle first (if_id_flush=0), then 2 control-squash cycles; 3 total stall cycles.
- JR (op=000000, funct=001000) with CTRL_BUBBLES=4 -> pc_enable=0 for 4 cycles. Assert reset in cycle 2 -> outputs take reset values asynchronously; after release, IDLE with stall_cycles=0.
- CNT_W=4 with 20 consecutive J instructions, CTRL_BUBBLES=1 -> stall_cycles saturates at 15 and holds.
